// File: rtl/output_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : output_buffer_ctrl_if
// Brief    : Control, sense-amp, encoder and read-port bundle of the
//            output-buffer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface output_buffer_ctrl_if #(
    parameter int NUM_COL = 8,
    parameter int CW      = $clog2(NUM_COL)
);
    logic                  start_i;
    logic                  clear_i;
    logic                  sa_valid_i;
    logic [16*NUM_COL-1:0] sa_data_i;
    logic [7:0]            enc_out_1_o;
    logic [7:0]            enc_out_2_o;
    logic [6:0]            enc_result_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  timeout_o;
    logic                  err_o;
    logic [CW-1:0]         err_col_o;
    logic                  rd_en_i;
    logic [CW-1:0]         rd_addr_i;
    logic [6:0]            rd_data_o;

    modport slave (
        input  start_i, clear_i, sa_valid_i, sa_data_i, enc_result_i,
               rd_en_i, rd_addr_i,
        output enc_out_1_o, enc_out_2_o, busy_o, done_o, timeout_o,
               err_o, err_col_o, rd_data_o
    );

    modport master (
        output start_i, clear_i, sa_valid_i, sa_data_i, enc_result_i,
               rd_en_i, rd_addr_i,
        input  enc_out_1_o, enc_out_2_o, busy_o, done_o, timeout_o,
               err_o, err_col_o, rd_data_o
    );
endinterface
`default_nettype wire

// File: rtl/output_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : output_buffer_ctrl
// Brief    : Captures a sense-amp word, walks its columns through the external
//            encoder into a result buffer, flags bad codes and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module output_buffer_ctrl #(
    parameter int NUM_COL = 8,
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    output_buffer_ctrl_if.slave bus
);
    localparam int CW = $clog2(NUM_COL);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_SA = 2'd1,
        S_ENCODE  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;
    logic [CW-1:0] err_col_q, err_col_d;
    logic [15:0]   cap_q [NUM_COL];
    logic [15:0]   cap_d [NUM_COL];
    logic [6:0]    buf_q [NUM_COL];
    logic [6:0]    buf_d [NUM_COL];
    logic [6:0]    rd_data_q, rd_data_d;
    logic [7:0]    enc_1, enc_2;

    function automatic logic therm_ok(input logic [7:0] b);
        case (b)
            8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0,
            8'hF8, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        err_col_d = err_col_q;
        cap_d     = cap_q;
        buf_d     = buf_q;
        rd_data_d = rd_data_q;
        enc_1     = 8'h00;
        enc_2     = 8'h00;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    state_d   = S_WAIT_SA;
                    timeout_d = 1'b0;
                    err_d     = 1'b0;
                    err_col_d = '0;
                    tcnt_d    = '0;
                end else if (state_q == S_DONE && bus.clear_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_SA: begin
                // A valid word arriving in the final wait cycle beats the timeout.
                if (bus.sa_valid_i) begin
                    for (int c = 0; c < NUM_COL; c++) begin
                        cap_d[c] = bus.sa_data_i[16*c +: 16];
                    end
                    col_d   = '0;
                    state_d = S_ENCODE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_ENCODE: begin
                enc_1         = cap_q[col_q][15:8];
                enc_2         = cap_q[col_q][7:0];
                buf_d[col_q]  = bus.enc_result_i;
                if ((!therm_ok(enc_1) || !therm_ok(enc_2)) && !err_q) begin
                    err_d     = 1'b1;
                    err_col_d = col_q;
                end
                if (col_q == CW'(NUM_COL - 1)) begin
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reads see the pre-write buffer contents of this cycle.
        if (bus.rd_en_i) begin
            rd_data_d = (int'(bus.rd_addr_i) < NUM_COL) ? buf_q[bus.rd_addr_i] : 7'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            err_col_q <= '0;
            rd_data_q <= 7'd0;
            for (int c = 0; c < NUM_COL; c++) begin
                cap_q[c] <= 16'h0000;
                buf_q[c] <= 7'd0;
            end
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            err_col_q <= err_col_d;
            rd_data_q <= rd_data_d;
            cap_q     <= cap_d;
            buf_q     <= buf_d;
        end
    end

    assign bus.enc_out_1_o = enc_1;
    assign bus.enc_out_2_o = enc_2;
    assign bus.busy_o      = (state_q == S_WAIT_SA) || (state_q == S_ENCODE);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.timeout_o   = timeout_q;
    assign bus.err_o       = err_q;
    assign bus.err_col_o   = err_col_q;
    assign bus.rd_data_o   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_output_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_buffer_ctrl
// Brief    : Directed bench for output_buffer_ctrl with a behavioural encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_buffer_ctrl;
    localparam int NUM_COL = 8;
    localparam int NC2     = 5;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    output_buffer_ctrl_if #(.NUM_COL(NUM_COL)) u_if ();
    output_buffer_ctrl_if #(.NUM_COL(NC2))     u_if2 ();

    output_buffer_ctrl #(.NUM_COL(NUM_COL), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    // Narrower instance shares all stimulus; its 3-bit address reaches past NUM_COL.
    output_buffer_ctrl #(.NUM_COL(NC2), .TIMEOUT(TIMEOUT)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if2.slave)
    );

    function automatic int therm_n(input logic [7:0] b);
        case (b)
            8'h00: return 0;
            8'h80: return 1;
            8'hC0: return 2;
            8'hE0: return 3;
            8'hF0: return 4;
            8'hF8: return 5;
            8'hFC: return 6;
            8'hFE: return 7;
            8'hFF: return 8;
            default: return -1;
        endcase
    endfunction

    function automatic logic [6:0] enc_model(input logic [7:0] a, input logic [7:0] b);
        int na, nb;
        na = therm_n(a);
        nb = therm_n(b);
        if (na < 0 || nb < 0) return 7'd0;
        return 7'(8 * na + nb);
    endfunction

    assign u_if.enc_result_i  = enc_model(u_if.enc_out_1_o, u_if.enc_out_2_o);
    assign u_if2.enc_result_i = enc_model(u_if2.enc_out_1_o, u_if2.enc_out_2_o);
    assign u_if2.start_i      = u_if.start_i;
    assign u_if2.clear_i      = u_if.clear_i;
    assign u_if2.sa_valid_i   = u_if.sa_valid_i;
    assign u_if2.sa_data_i    = u_if.sa_data_i[16*NC2-1:0];
    assign u_if2.rd_en_i      = u_if.rd_en_i;
    assign u_if2.rd_addr_i    = u_if.rd_addr_i;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int a, output logic [6:0] d1, output logic [6:0] d2);
        u_if.rd_en_i   = 1'b1;
        u_if.rd_addr_i = 3'(a);
        tick();
        u_if.rd_en_i   = 1'b0;
        d1 = u_if.rd_data_o;
        d2 = u_if2.rd_data_o;
    endtask

    task automatic start_run();
        u_if.start_i = 1'b1;
        tick();
        u_if.start_i = 1'b0;
    endtask

    task automatic pulse_valid();
        u_if.sa_valid_i = 1'b1;
        tick();
        u_if.sa_valid_i = 1'b0;
    endtask

    task automatic load_nominal();
        for (int c = 0; c < NUM_COL; c++) begin
            u_if.sa_data_i[16*c +: 16] = (c == NUM_COL - 1) ? 16'hFFFF : 16'hE0FC;
        end
    endtask

    initial begin
        logic [6:0] d1, d2;
        rst             = 1'b1;
        u_if.start_i    = 1'b0;
        u_if.clear_i    = 1'b0;
        u_if.sa_valid_i = 1'b0;
        u_if.sa_data_i  = '0;
        u_if.rd_en_i    = 1'b0;
        u_if.rd_addr_i  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(u_if.busy_o), 32'd0);
        chk("rst_done", 32'(u_if.done_o), 32'd0);
        chk("rst_timeout", 32'(u_if.timeout_o), 32'd0);
        chk("rst_err", 32'(u_if.err_o), 32'd0);
        chk("rst_err_col", 32'(u_if.err_col_o), 32'd0);
        chk("rst_rd_data", 32'(u_if.rd_data_o), 32'd0);
        rst = 1'b0;

        // Sense-amp activity while idle must not reach the encoder or the buffer.
        for (int c = 0; c < NUM_COL; c++) begin
            u_if.sa_data_i = '0;
            u_if.sa_data_i[16*c +: 16] = 16'hFFFF;
            pulse_valid();
            chk($sformatf("idle_enc1_c%0d", c), 32'(u_if.enc_out_1_o), 32'd0);
            chk($sformatf("idle_enc2_c%0d", c), 32'(u_if.enc_out_2_o), 32'd0);
            chk($sformatf("idle_busy_c%0d", c), 32'(u_if.busy_o), 32'd0);
        end
        for (int a = 0; a < NUM_COL; a++) begin
            rd(a, d1, d2);
            chk($sformatf("rst_buf%0d", a), 32'(d1), 32'd0);
        end

        // Malformed codes: col2 output_1=A0, col5 output_2=01.
        u_if.sa_data_i = '0;
        u_if.sa_data_i[16*2+8 +: 8] = 8'hA0;
        u_if.sa_data_i[16*5 +: 8]   = 8'h01;
        start_run();
        tick();
        pulse_valid();
        repeat (NUM_COL) tick();
        chk("bad_done", 32'(u_if.done_o), 32'd1);
        chk("bad_err", 32'(u_if.err_o), 32'd1);
        chk("bad_err_col", 32'(u_if.err_col_o), 32'd2);
        chk("bad_timeout", 32'(u_if.timeout_o), 32'd0);
        rd(2, d1, d2);
        chk("bad_buf2", 32'(d1), 32'd0);
        rd(5, d1, d2);
        chk("bad_buf5", 32'(d1), 32'd0);

        // Nominal run from DONE, sa_valid 3 cycles after start, start pulsed mid-ENCODE.
        load_nominal();
        start_run();
        chk("nom_busy_wait", 32'(u_if.busy_o), 32'd1);
        chk("nom_err_cleared", 32'(u_if.err_o), 32'd0);
        tick();
        tick();
        pulse_valid();
        chk("nom_enc1_c0", 32'(u_if.enc_out_1_o), 32'hE0);
        chk("nom_enc2_c0", 32'(u_if.enc_out_2_o), 32'hFC);
        for (int k = 1; k < NUM_COL; k++) begin
            if (k == 3) u_if.start_i = 1'b1;
            tick();
            u_if.start_i = 1'b0;
            chk($sformatf("nom_busy_k%0d", k), 32'(u_if.busy_o), 32'd1);
            chk($sformatf("nom_done_k%0d", k), 32'(u_if.done_o), 32'd0);
        end
        chk("nom_enc1_c7", 32'(u_if.enc_out_1_o), 32'hFF);
        chk("nom_enc2_c7", 32'(u_if.enc_out_2_o), 32'hFF);
        tick();
        chk("nom_done", 32'(u_if.done_o), 32'd1);
        chk("nom_busy_end", 32'(u_if.busy_o), 32'd0);
        chk("nom_enc1_done", 32'(u_if.enc_out_1_o), 32'd0);
        chk("nom_err", 32'(u_if.err_o), 32'd0);
        chk("nom_timeout", 32'(u_if.timeout_o), 32'd0);
        chk("nom2_done", 32'(u_if2.done_o), 32'd1);
        for (int a = 0; a < NUM_COL; a++) begin
            rd(a, d1, d2);
            chk($sformatf("nom_buf%0d", a), 32'(d1), (a == NUM_COL - 1) ? 32'd72 : 32'd30);
            chk($sformatf("nom2_buf%0d", a), 32'(d2), (a < NC2) ? 32'd30 : 32'd0);
        end

        // Timeout: no sa_valid for TIMEOUT cycles.
        start_run();
        chk("to_busy_0", 32'(u_if.busy_o), 32'd1);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk($sformatf("to_busy_%0d", k), 32'(u_if.busy_o), 32'd1);
        end
        tick();
        chk("to_done", 32'(u_if.done_o), 32'd1);
        chk("to_timeout", 32'(u_if.timeout_o), 32'd1);
        chk("to_busy_end", 32'(u_if.busy_o), 32'd0);
        rd(0, d1, d2);
        chk("to_buf0_kept", 32'(d1), 32'd30);
        rd(7, d1, d2);
        chk("to_buf7_kept", 32'(d1), 32'd72);

        // start+clear together in DONE: start wins, sticky flags cleared.
        u_if.clear_i = 1'b1;
        start_run();
        u_if.clear_i = 1'b0;
        chk("sc_busy", 32'(u_if.busy_o), 32'd1);
        chk("sc_done", 32'(u_if.done_o), 32'd0);
        chk("sc_timeout", 32'(u_if.timeout_o), 32'd0);
        pulse_valid();
        repeat (NUM_COL) tick();
        chk("sc_run_done", 32'(u_if.done_o), 32'd1);

        // clear in DONE returns to IDLE.
        u_if.clear_i = 1'b1;
        tick();
        u_if.clear_i = 1'b0;
        chk("clr_done", 32'(u_if.done_o), 32'd0);
        chk("clr_busy", 32'(u_if.busy_o), 32'd0);

        // sa_valid in the final WAIT_SA cycle wins over the timeout.
        start_run();
        repeat (TIMEOUT - 1) tick();
        chk("late_busy", 32'(u_if.busy_o), 32'd1);
        pulse_valid();
        chk("late_busy_enc", 32'(u_if.busy_o), 32'd1);
        chk("late_timeout", 32'(u_if.timeout_o), 32'd0);
        chk("late_enc1_c0", 32'(u_if.enc_out_1_o), 32'hE0);
        repeat (NUM_COL) tick();
        chk("late_done", 32'(u_if.done_o), 32'd1);
        chk("late_timeout_end", 32'(u_if.timeout_o), 32'd0);

        // Reset while encoding column 3.
        start_run();
        pulse_valid();
        repeat (3) tick();
        chk("mid_enc1_c3", 32'(u_if.enc_out_1_o), 32'hE0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", 32'(u_if.busy_o), 32'd0);
        chk("mid_done", 32'(u_if.done_o), 32'd0);
        chk("mid_enc1", 32'(u_if.enc_out_1_o), 32'd0);
        tick();
        chk("mid_idle_busy", 32'(u_if.busy_o), 32'd0);
        for (int a = 0; a < NUM_COL; a++) begin
            rd(a, d1, d2);
            chk($sformatf("mid_buf%0d", a), 32'(d1), 32'd0);
        end

        // Fresh run; a read of the column being written returns the old value.
        start_run();
        pulse_valid();
        u_if.rd_en_i   = 1'b1;
        u_if.rd_addr_i = 3'd0;
        tick();
        chk("rw_old", 32'(u_if.rd_data_o), 32'd0);
        tick();
        u_if.rd_en_i = 1'b0;
        chk("rw_new", 32'(u_if.rd_data_o), 32'd30);
        repeat (NUM_COL - 2) tick();
        chk("post_done", 32'(u_if.done_o), 32'd1);
        rd(7, d1, d2);
        chk("post_buf7", 32'(d1), 32'd72);
        tick();
        chk("rd_hold", 32'(u_if.rd_data_o), 32'd72);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
